// File: rtl/postfix_stream_evaluator.sv
// Purpose : evaluates postfix token streams on a DEPTH-entry signed stack; one result per expression.
// Latency : operand 1 cycle, operator 2 cycles (accept + EXEC); End accepted at edge N -> res_valid in cycle N+1.
// Backpr. : tok_ready drops during EXEC and while a result waits; the result is held stable until res_ready.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   tok_valid/tok_ready             token handshake
//   tok_kind                        00 operand, 01 operator, 10 end, 11 illegal
//   tok_op                          00 add, 01 sub, 10 mul, 11 illegal
//   tok_data                        operand value
//   res_valid/res_ready             result handshake
//   res_data                        expression value, 0 when any error bit is set
//   res_err                         [0] overflow, [1] underflow/unbalanced, [2] illegal token
//   res_ovf                         arithmetic overflow seen in this expression
//   depth_o                         registered stack occupancy
//
// Build option: define EVAL_SAT_EN to saturate overflowing arithmetic instead of wrapping.
module postfix_stream_evaluator #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int SP_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic [1:0]       tok_kind,
    input  logic [1:0]       tok_op,
    input  logic [WIDTH-1:0] tok_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [2:0]       res_err,
    output logic             res_ovf,
    output logic [SP_W-1:0]  depth_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0] SP_TWO  = SP_W'(2);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

    localparam logic [1:0] KIND_OPND = 2'b00;
    localparam logic [1:0] KIND_OPER = 2'b01;
    localparam logic [1:0] KIND_END  = 2'b10;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_ACCEPT  = 2'd0,
        ST_EXEC    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_RESULT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [2:0]        err_q, err_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        op_q, op_d;

    logic [WIDTH-1:0]  stack_q [DEPTH];

    logic              tok_fire;
    logic              push_en;
    logic              exec_en;

    logic [SP_W-1:0]   sp_m1;
    logic [SP_W-1:0]   sp_m2;
    logic [IDX_W-1:0]  idx_push;
    logic [IDX_W-1:0]  idx_a;
    logic [IDX_W-1:0]  idx_b;

    logic [WIDTH-1:0]   opnd_a;
    logic [WIDTH-1:0]   opnd_b;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] exact;
    logic               alu_ovf;
    logic [WIDTH-1:0]   alu_res;

    // ------------------------------------------------------------------
    // Stack addressing: push goes to stack[sp], EXEC reads the top two
    // entries and writes the result back into the lower one.
    // ------------------------------------------------------------------
    assign sp_m1    = sp_q - SP_ONE;
    assign sp_m2    = sp_q - SP_TWO;
    assign idx_push = sp_q[IDX_W-1:0];
    assign idx_b    = sp_m1[IDX_W-1:0];
    assign idx_a    = sp_m2[IDX_W-1:0];

    assign opnd_a = stack_q[idx_a];
    assign opnd_b = stack_q[idx_b];

    // Sign-extend to double width so add, sub and mul are all exact; the
    // low 2*WIDTH bits of the product of sign-extended values are the true
    // signed product.
    assign a_ext = {{WIDTH{opnd_a[WIDTH-1]}}, opnd_a};
    assign b_ext = {{WIDTH{opnd_b[WIDTH-1]}}, opnd_b};

    always_comb begin
        exact = '0;
        case (op_q)
            OP_ADD:  exact = a_ext + b_ext;
            OP_SUB:  exact = a_ext - b_ext;
            OP_MUL:  exact = a_ext * b_ext;
            default: exact = '0;
        endcase
    end

    // The exact value fits in WIDTH when the upper WIDTH+1 bits are all
    // copies of the result sign bit.
    assign alu_ovf = !((&exact[2*WIDTH-1:WIDTH-1]) || (~|exact[2*WIDTH-1:WIDTH-1]));

`ifdef EVAL_SAT_EN
    always_comb begin
        alu_res = exact[WIDTH-1:0];
        if (alu_ovf) begin
            alu_res = exact[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign alu_res = exact[WIDTH-1:0];
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign tok_fire = tok_valid && tok_ready;

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        op_d    = op_q;
        push_en = 1'b0;
        exec_en = 1'b0;

        case (state_q)
            ST_ACCEPT: begin
                if (tok_fire) begin
                    case (tok_kind)
                        KIND_OPND: begin
                            if (sp_q == SP_FULL) begin
                                err_d[0] = 1'b1;
                                state_d  = ST_DISCARD;
                            end else begin
                                push_en = 1'b1;
                                sp_d    = sp_q + SP_ONE;
                            end
                        end
                        KIND_OPER: begin
                            // An illegal opcode is reported as such even
                            // when the stack would also underflow.
                            if (tok_op == OP_ILL) begin
                                err_d[2] = 1'b1;
                                state_d  = ST_DISCARD;
                            end else if (sp_q < SP_TWO) begin
                                err_d[1] = 1'b1;
                                state_d  = ST_DISCARD;
                            end else begin
                                op_d    = tok_op;
                                state_d = ST_EXEC;
                            end
                        end
                        KIND_END: begin
                            if (sp_q != SP_ONE) begin
                                err_d[1] = 1'b1;
                            end
                            state_d = ST_RESULT;
                        end
                        default: begin
                            err_d[2] = 1'b1;
                            state_d  = ST_DISCARD;
                        end
                    endcase
                end
            end

            ST_EXEC: begin
                exec_en = 1'b1;
                sp_d    = sp_m1;
                if (alu_ovf) begin
                    ovf_d = 1'b1;
                end
                state_d = ST_ACCEPT;
            end

            ST_DISCARD: begin
                // Tokens are swallowed; only End matters. Error bits stay as
                // they were when the first error was seen.
                if (tok_fire && (tok_kind == KIND_END)) begin
                    state_d = ST_RESULT;
                end
            end

            ST_RESULT: begin
                if (res_ready) begin
                    sp_d    = '0;
                    err_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_ACCEPT;
                end
            end

            default: state_d = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCEPT;
            sp_q    <= '0;
            err_q   <= '0;
            ovf_q   <= 1'b0;
            op_q    <= OP_ADD;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            op_q    <= op_d;
        end
    end

    // Stack storage is pure datapath; occupancy (sp) guards every read, so
    // it needs no reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[idx_push] <= tok_data;
        end else if (exec_en) begin
            stack_q[idx_a] <= alu_res;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registered state, hence stable while a
    // result is waiting for res_ready.
    // ------------------------------------------------------------------
    assign tok_ready = rst_n && ((state_q == ST_ACCEPT) || (state_q == ST_DISCARD));
    assign res_valid = (state_q == ST_RESULT);
    assign res_data  = (res_valid && (err_q == 3'b000)) ? stack_q[0] : '0;
    assign res_err   = res_valid ? err_q : 3'b000;
    assign res_ovf   = res_valid && ovf_q;
    assign depth_o   = sp_q;

endmodule

// File: tb/tb_postfix_stream_evaluator.sv
module tb_postfix_stream_evaluator;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int SP_W  = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tok_valid;
    logic             tok_ready;
    logic [1:0]       tok_kind;
    logic [1:0]       tok_op;
    logic [WIDTH-1:0] tok_data;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [2:0]       res_err;
    logic             res_ovf;
    logic [SP_W-1:0]  depth_o;

    int n_tests = 0;
    int n_fail  = 0;

    // token list for the expression under test
    logic [1:0]  qk[$];
    logic [1:0]  qo[$];
    logic [31:0] qd[$];

    postfix_stream_evaluator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_kind  (tok_kind),
        .tok_op    (tok_op),
        .tok_data  (tok_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .res_ovf   (res_ovf),
        .depth_o   (depth_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model(output logic [31:0] d, output logic [2:0] e, output logic o);
        longint      st[$];
        longint      a, b, r;
        logic [31:0] r32;
        bit          disc;
        disc = 0;
        e = 3'b000;
        o = 1'b0;
        d = 32'd0;
        for (int i = 0; i < qk.size(); i++) begin
            if (disc) begin
                if (qk[i] == 2'b10) break;
                continue;
            end
            if (qk[i] == 2'b00) begin
                if (st.size() == DEPTH) begin e[0] = 1'b1; disc = 1; end
                else st.push_back(longint'($signed(qd[i])));
            end else if (qk[i] == 2'b01) begin
                if (qo[i] == 2'b11) begin e[2] = 1'b1; disc = 1; end
                else if (st.size() < 2) begin e[1] = 1'b1; disc = 1; end
                else begin
                    b = st.pop_back();
                    a = st.pop_back();
                    if (qo[i] == 2'b00)      r = a + b;
                    else if (qo[i] == 2'b01) r = a - b;
                    else                     r = a * b;
                    r32 = r[31:0];
                    if (r > 64'sd2147483647 || r < -64'sd2147483648) begin
                        o = 1'b1;
`ifdef EVAL_SAT_EN
                        r32 = (r < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
                    end
                    st.push_back(longint'($signed(r32)));
                end
            end else if (qk[i] == 2'b10) begin
                if (st.size() != 1) e[1] = 1'b1;
                break;
            end else begin
                e[2] = 1'b1;
                disc = 1;
            end
        end
        if (e == 3'b000) begin
            a = st[0];
            d = a[31:0];
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic add_tok(input logic [1:0] k, input logic [1:0] op, input logic [31:0] d);
        qk.push_back(k);
        qo.push_back(op);
        qd.push_back(d);
    endtask

    task automatic clear_q();
        qk.delete();
        qo.delete();
        qd.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_token(input logic [1:0] k, input logic [1:0] op, input logic [31:0] d);
        int guard;
        tok_kind  = k;
        tok_op    = op;
        tok_data  = d;
        tok_valid = 1'b1;
        guard = 0;
        while (tok_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            check_eq("tok_accept_timeout", 64'd0, 64'd1);
            tok_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_all();
        for (int i = 0; i < qk.size(); i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send_token(qk[i], qo[i], qd[i]);
        end
    endtask

    // Entered at the negedge right after End was accepted.
    task automatic take_result(input string tag, input logic [31:0] ed, input logic [2:0] ee,
                               input logic eo, input int hold);
        logic [31:0] d0;
        logic [2:0]  e0;
        logic        o0;
        check_eq({tag, "_latency_vld"}, 64'(res_valid), 64'd1);
        d0 = res_data;
        e0 = res_err;
        o0 = res_ovf;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_hold_vld"}, 64'(res_valid), 64'd1);
            check_eq({tag, "_hold_data"}, 64'(res_data), 64'(d0));
            check_eq({tag, "_hold_err"}, 64'(res_err), 64'(e0));
            check_eq({tag, "_hold_ovf"}, 64'(res_ovf), 64'(o0));
            check_eq({tag, "_hold_rdy"}, 64'(tok_ready), 64'd0);
        end
        check_eq({tag, "_data"}, 64'(res_data), 64'(ed));
        check_eq({tag, "_err"}, 64'(res_err), 64'(ee));
        check_eq({tag, "_ovf"}, 64'(res_ovf), 64'(eo));
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, "_post_vld"}, 64'(res_valid), 64'd0);
        check_eq({tag, "_post_depth"}, 64'(depth_o), 64'd0);
    endtask

    task automatic run_expect(input string tag, input logic [31:0] ed, input logic [2:0] ee,
                              input logic eo, input int hold);
        send_all();
        take_result(tag, ed, ee, eo, hold);
        clear_q();
    endtask

    task automatic run_model(input string tag, input int hold);
        logic [31:0] md;
        logic [2:0]  me;
        logic        mo;
        model(md, me, mo);
        send_all();
        take_result(tag, md, me, mo, hold);
        clear_q();
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic gen_random();
        int mode, n, cnt, pushed, idx;
        clear_q();
        mode = $urandom_range(0, 9);
        if (mode <= 5) begin
            n = $urandom_range(1, 8);
            cnt = 0;
            pushed = 0;
            while (pushed < n || cnt > 1) begin
                if (pushed < n && (cnt < 2 || $urandom_range(0, 1) == 1)) begin
                    add_tok(2'b00, 2'b00, rand_val());
                    cnt++;
                    pushed++;
                end else begin
                    add_tok(2'b01, 2'($urandom_range(0, 2)), 32'd0);
                    cnt--;
                end
            end
            if (mode == 5) begin
                idx = $urandom_range(0, qk.size() - 1);
                if ($urandom_range(0, 1) == 1) begin
                    qk[idx] = 2'b01;
                    qo[idx] = 2'b11;
                end else begin
                    qk[idx] = 2'b11;
                end
            end
        end else if (mode == 6) begin
            n = $urandom_range(2, 3);
            for (int i = 0; i < n; i++) add_tok(2'b00, 2'b00, rand_val());
        end else if (mode == 7) begin
            n = $urandom_range(14, 18);
            for (int i = 0; i < n; i++) add_tok(2'b00, 2'b00, rand_val());
        end else begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                add_tok(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rand_val());
                if (qk[qk.size() - 1] == 2'b10) qk[qk.size() - 1] = 2'b00;
            end
        end
        add_tok(2'b10, 2'b00, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        tok_valid = 1'b0;
        tok_kind  = 2'b00;
        tok_op    = 2'b00;
        tok_data  = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tok_ready", 64'(tok_ready), 64'd0);
        check_eq("rst_res_valid", 64'(res_valid), 64'd0);
        check_eq("rst_res_data", 64'(res_data), 64'd0);
        check_eq("rst_res_err", 64'(res_err), 64'd0);
        check_eq("rst_res_ovf", 64'(res_ovf), 64'd0);
        check_eq("rst_depth", 64'(depth_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_tok_ready", 64'(tok_ready), 64'd1);

        // 3,4,+,2,*,End -> 14 ; EXEC bubble on tok_ready
        send_token(2'b00, 2'b00, 32'd3);
        send_token(2'b00, 2'b00, 32'd4);
        check_eq("t1_depth2", 64'(depth_o), 64'd2);
        send_token(2'b01, 2'b00, 32'd0);
        check_eq("t1_exec_rdy", 64'(tok_ready), 64'd0);
        @(negedge clk);
        check_eq("t1_after_exec_rdy", 64'(tok_ready), 64'd1);
        check_eq("t1_depth1", 64'(depth_o), 64'd1);
        send_token(2'b00, 2'b00, 32'd2);
        send_token(2'b01, 2'b10, 32'd0);
        send_token(2'b10, 2'b00, 32'd0);
        take_result("t1", 32'd14, 3'b000, 1'b0, 1);

        // subtraction order
        add_tok(2'b00, 2'b00, 32'd10); add_tok(2'b00, 2'b00, 32'd3);
        add_tok(2'b01, 2'b01, 32'd0);  add_tok(2'b10, 2'b00, 32'd0);
        run_expect("t2a", 32'd7, 3'b000, 1'b0, 0);
        add_tok(2'b00, 2'b00, 32'd3);  add_tok(2'b00, 2'b00, 32'd10);
        add_tok(2'b01, 2'b01, 32'd0);  add_tok(2'b10, 2'b00, 32'd0);
        run_expect("t2b", 32'hFFFF_FFF9, 3'b000, 1'b0, 0);

        // overflow
        add_tok(2'b00, 2'b00, 32'h7FFF_FFFF); add_tok(2'b00, 2'b00, 32'd1);
        add_tok(2'b01, 2'b00, 32'd0);         add_tok(2'b10, 2'b00, 32'd0);
`ifdef EVAL_SAT_EN
        run_expect("t3", 32'h7FFF_FFFF, 3'b000, 1'b1, 0);
`else
        run_expect("t3", 32'h8000_0000, 3'b000, 1'b1, 0);
`endif

        // underflow, then tokens dropped until End
        add_tok(2'b00, 2'b00, 32'd5); add_tok(2'b01, 2'b00, 32'd0);
        add_tok(2'b00, 2'b00, 32'd7); add_tok(2'b10, 2'b00, 32'd0);
        run_expect("t4a", 32'd0, 3'b010, 1'b0, 0);
        for (int i = 0; i < 17; i++) add_tok(2'b00, 2'b00, 32'(i + 1));
        add_tok(2'b10, 2'b00, 32'd0);
        run_expect("t4b", 32'd0, 3'b001, 1'b0, 0);

        // unbalanced and illegal kind
        add_tok(2'b00, 2'b00, 32'd2); add_tok(2'b00, 2'b00, 32'd3);
        add_tok(2'b10, 2'b00, 32'd0);
        run_expect("t5a", 32'd0, 3'b010, 1'b0, 0);
        add_tok(2'b11, 2'b00, 32'd0); add_tok(2'b10, 2'b00, 32'd0);
        run_expect("t5b", 32'd0, 3'b100, 1'b0, 0);

        // backpressure: result held 5 cycles
        add_tok(2'b00, 2'b00, 32'd9); add_tok(2'b00, 2'b00, 32'd6);
        add_tok(2'b01, 2'b10, 32'd0); add_tok(2'b10, 2'b00, 32'd0);
        run_expect("t6_hold", 32'd54, 3'b000, 1'b0, 5);

        // reset mid-expression
        for (int i = 0; i < 4; i++) send_token(2'b00, 2'b00, 32'(i + 100));
        check_eq("t6_depth4", 64'(depth_o), 64'd4);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_depth", 64'(depth_o), 64'd0);
        check_eq("t6_rst_vld", 64'(res_valid), 64'd0);
        check_eq("t6_rst_rdy", 64'(tok_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        add_tok(2'b00, 2'b00, 32'd6); add_tok(2'b00, 2'b00, 32'd7);
        add_tok(2'b01, 2'b10, 32'd0); add_tok(2'b10, 2'b00, 32'd0);
        run_expect("t6_after_rst", 32'd42, 3'b000, 1'b0, 0);

        // randomized expressions against the reference model
        for (int t = 0; t < 60; t++) begin
            gen_random();
            run_model($sformatf("rnd%0d", t), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
